hr_window_monitor: RTL and testbench

HR_WINDOW_MONITOR -- requirements
Module: hr_window_monitor

---
 rtl/hr_window_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_hr_window_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hr_window_monitor.sv
// hr_window_monitor: heart-rate monitor. It computes a DEPTH-sample moving
// average and tracks the session maximum, minimum and sample count. Each
// sample is classified as SAFE, WARNING or EMERGENCY, and the state changes
// only after PERSIST consecutive out-of-class samples. A sticky alarm flag
// records any entry into EMERGENCY.
module hr_window_monitor #(
  parameter int HR_W     = 8,
  parameter int DEPTH    = 8,
  parameter int WARN_TH  = 150,
  parameter int EMERG_TH = 180,
  parameter int PERSIST  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic [HR_W-1:0] hr_input,
  input  logic            clear,
  input  logic            alarm_ack,
  output logic [HR_W-1:0] avg_hr,
  output logic            avg_valid,
  output logic [HR_W-1:0] max_hr,
  output logic [HR_W-1:0] min_hr,
  output logic [1:0]      hr_state,
  output logic            alarm,
  output logic            alarm_latched,
  output logic [15:0]     sample_count
);

  localparam int LOG2D  = $clog2(DEPTH);
  localparam int SUM_W  = HR_W + LOG2D;
  localparam int PTR_W  = LOG2D;
  localparam int FILL_W = LOG2D + 1;

  localparam logic [FILL_W-1:0] FILL_FULL    = FILL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST     = PTR_W'(DEPTH - 1);
  localparam logic [HR_W-1:0]   WARN_LIM     = HR_W'(WARN_TH);
  localparam logic [HR_W-1:0]   EMERG_LIM    = HR_W'(EMERG_TH);
  localparam logic [3:0]        PERSIST_LAST = 4'(PERSIST - 1);

  typedef enum logic [1:0] {
    ST_SAFE  = 2'b00,
    ST_WARN  = 2'b01,
    ST_EMERG = 2'b10
  } state_t;

  // Map one instantaneous rate onto its class; thresholds are inclusive lower bounds.
  function automatic state_t classify(input logic [HR_W-1:0] hr);
    if (hr < WARN_LIM) begin
      return ST_SAFE;
    end else if (hr < EMERG_LIM) begin
      return ST_WARN;
    end else begin
      return ST_EMERG;
    end
  endfunction

  // 16-bit increment that sticks at all ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Window mean by truncating shift; the sum width makes the top HR_W bits the quotient.
  function automatic logic [HR_W-1:0] window_mean(input logic [SUM_W-1:0] s);
    return s[SUM_W-1 -: HR_W];
  endfunction

  // Window and statistics state
  logic [HR_W-1:0]   hist_q [DEPTH];
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [HR_W-1:0]   avg_d;
  logic              avg_valid_d;
  logic [HR_W-1:0]   max_d;
  logic [HR_W-1:0]   min_d;
  logic [15:0]       count_d;

  // Classification state
  state_t            state_q;
  state_t            state_d;
  state_t            cls;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              enter_emerg;
  logic              latched_d;

  // A clear in the same cycle drops the sample entirely.
  logic accept;
  assign accept = sample_valid & ~clear;

  assign cls      = classify(hr_input);
  assign hr_state = state_q;

  // Next-value logic for the window, running sum and session statistics.
  always_comb begin
    sum_d   = sum_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    max_d   = max_hr;
    min_d   = min_hr;
    count_d = sample_count;
    if (accept) begin
      // The entry about to be overwritten is the oldest sample, so drop it from the sum.
      sum_d   = sum_q + SUM_W'(hr_input) - SUM_W'(hist_q[ptr_q]);
      fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      max_d   = (hr_input >= max_hr) ? hr_input : max_hr;
      min_d   = (hr_input <= min_hr) ? hr_input : min_hr;
      count_d = sat_inc16(sample_count);
    end
    avg_valid_d = (fill_d == FILL_FULL);
    avg_d       = avg_valid_d ? window_mean(sum_d) : '0;
  end

  // Persistence filter: the state moves only after PERSIST consecutive
  // out-of-class samples. The class of the last sample in that run selects
  // the destination, so SAFE and EMERGENCY can switch directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (cls == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == PERSIST_LAST) begin
        state_d = cls;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Sticky alarm: a new entry into EMERGENCY wins over a simultaneous acknowledge.
  // The acknowledge is ignored while the state is still EMERGENCY.
  always_comb begin
    enter_emerg = (state_d == ST_EMERG) && (state_q != ST_EMERG);
    latched_d   = alarm_latched;
    if (enter_emerg) begin
      latched_d = 1'b1;
    end else if (alarm_ack && (state_q != ST_EMERG)) begin
      latched_d = 1'b0;
    end
  end

  // Classification state register, alarm outputs and persistence counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SAFE;
      cnt_q         <= '0;
      alarm         <= 1'b0;
      alarm_latched <= 1'b0;
    end else if (clear) begin
      state_q       <= ST_SAFE;
      cnt_q         <= '0;
      alarm         <= 1'b0;
      alarm_latched <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alarm         <= (state_d == ST_EMERG);
      alarm_latched <= latched_d;
    end
  end

  // Window buffer, running sum, fill/pointer and registered statistics outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      ptr_q        <= '0;
      avg_hr       <= '0;
      avg_valid    <= 1'b0;
      max_hr       <= '0;
      min_hr       <= '1;
      sample_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      ptr_q        <= '0;
      avg_hr       <= '0;
      avg_valid    <= 1'b0;
      max_hr       <= '0;
      min_hr       <= '1;
      sample_count <= '0;
    end else begin
      if (accept) hist_q[ptr_q] <= hr_input;
      sum_q        <= sum_d;
      fill_q       <= fill_d;
      ptr_q        <= ptr_d;
      avg_hr       <= avg_d;
      avg_valid    <= avg_valid_d;
      max_hr       <= max_d;
      min_hr       <= min_d;
      sample_count <= count_d;
    end
  end

endmodule

// File: tb/tb_hr_window_monitor.sv
// Directed testbench for hr_window_monitor (DEPTH=4, PERSIST=3).
module tb_hr_window_monitor;

  localparam int HR_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_valid = 1'b0;
  logic [HR_W-1:0] hr_input = '0;
  logic            clear = 1'b0;
  logic            alarm_ack = 1'b0;
  logic [HR_W-1:0] avg_hr;
  logic            avg_valid;
  logic [HR_W-1:0] max_hr;
  logic [HR_W-1:0] min_hr;
  logic [1:0]      hr_state;
  logic            alarm;
  logic            alarm_latched;
  logic [15:0]     sample_count;

  int n_checks = 0;
  int n_fail   = 0;

  hr_window_monitor #(
    .HR_W(HR_W), .DEPTH(4), .WARN_TH(150), .EMERG_TH(180), .PERSIST(3)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .hr_input(hr_input),
    .clear(clear), .alarm_ack(alarm_ack), .avg_hr(avg_hr), .avg_valid(avg_valid),
    .max_hr(max_hr), .min_hr(min_hr), .hr_state(hr_state), .alarm(alarm),
    .alarm_latched(alarm_latched), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_avg"},     32'(avg_hr),        32'd0);
    check({tag, "_avgv"},    32'(avg_valid),     32'd0);
    check({tag, "_max"},     32'(max_hr),        32'd0);
    check({tag, "_min"},     32'(min_hr),        32'd255);
    check({tag, "_state"},   32'(hr_state),      32'd0);
    check({tag, "_alarm"},   32'(alarm),         32'd0);
    check({tag, "_latched"}, 32'(alarm_latched), 32'd0);
    check({tag, "_count"},   32'(sample_count),  32'd0);
  endtask

  // Present one sample for one edge; outputs are readable on return.
  task automatic push(input logic [HR_W-1:0] v);
    sample_valid = 1'b1;
    hr_input     = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic pulse_ack();
    alarm_ack = 1'b1;
    @(posedge clk);
    #1;
    alarm_ack = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held
    #12;
    check_reset("rst");
    rst = 1'b0;

    // Window fill and moving average
    push(8'd100); push(8'd100); push(8'd100);
    check("avgv_3", 32'(avg_valid), 32'd0);
    check("avg_3",  32'(avg_hr),    32'd0);
    push(8'd100);
    check("avgv_4", 32'(avg_valid), 32'd1);
    check("avg_4",  32'(avg_hr),    32'd100);
    push(8'd140);
    check("avg_5",  32'(avg_hr),    32'd110);
    check("cnt_5",  32'(sample_count), 32'd5);
    // Idle cycles hold everything
    repeat (3) @(posedge clk);
    #1;
    check("hold_avg", 32'(avg_hr), 32'd110);
    check("hold_cnt", 32'(sample_count), 32'd5);

    // Persistence SAFE -> WARNING, and a run broken by an in-class sample
    do_clear();
    push(8'd160); push(8'd160);
    check("warn_2", 32'(hr_state), 32'd0);
    push(8'd160);
    check("warn_3", 32'(hr_state), 32'd1);
    do_clear();
    push(8'd160); push(8'd100); push(8'd160);
    check("broken_run", 32'(hr_state), 32'd0);
    push(8'd160);
    check("broken_run2", 32'(hr_state), 32'd0);

    // Mixed run: the last sample's class picks the destination
    do_clear();
    push(8'd160); push(8'd160); push(8'd200);
    check("mixed_state", 32'(hr_state), 32'd2);
    check("mixed_alarm", 32'(alarm), 32'd1);

    // Emergency, ignored ack, direct return to SAFE, then honoured ack
    do_clear();
    push(8'd200); push(8'd200);
    check("emerg_2", 32'(hr_state), 32'd0);
    push(8'd200);
    check("emerg_state", 32'(hr_state), 32'd2);
    check("emerg_alarm", 32'(alarm), 32'd1);
    check("emerg_latch", 32'(alarm_latched), 32'd1);
    pulse_ack();
    check("ack_in_emerg", 32'(alarm_latched), 32'd1);
    push(8'd100); push(8'd100); push(8'd100);
    check("safe_state", 32'(hr_state), 32'd0);
    check("safe_alarm", 32'(alarm), 32'd0);
    check("safe_latch", 32'(alarm_latched), 32'd1);
    pulse_ack();
    check("ack_in_safe", 32'(alarm_latched), 32'd0);

    // A new entry into EMERGENCY wins over a simultaneous ack
    push(8'd200); push(8'd200);
    alarm_ack = 1'b1;
    push(8'd200);
    alarm_ack = 1'b0;
    check("set_wins", 32'(alarm_latched), 32'd1);

    // Extremes and sample-count saturation
    do_clear();
    push(8'd255);
    check("ext1_max", 32'(max_hr), 32'd255);
    check("ext1_min", 32'(min_hr), 32'd255);
    push(8'd0);
    check("ext2_max", 32'(max_hr), 32'd255);
    check("ext2_min", 32'(min_hr), 32'd0);
    sample_valid = 1'b1;
    hr_input     = 8'd90;
    repeat (70000) @(posedge clk);
    #1;
    sample_valid = 1'b0;
    check("cnt_sat", 32'(sample_count), 32'd65535);

    // Clear with a coincident sample after 5 samples
    do_clear();
    repeat (5) push(8'd200);
    check("pre_clear_latch", 32'(alarm_latched), 32'd1);
    clear = 1'b1;
    push(8'd200);
    clear = 1'b0;
    check_reset("clr");
    push(8'd100);
    check("post_clear_cnt", 32'(sample_count), 32'd1);

    // Asynchronous reset mid-window, then a clean window of 80s
    do_clear();
    push(8'd250); push(8'd250); push(8'd250);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async");
    #1;
    rst = 1'b0;
    push(8'd80); push(8'd80); push(8'd80);
    check("rst_avgv_3", 32'(avg_valid), 32'd0);
    push(8'd80);
    check("rst_avgv_4", 32'(avg_valid), 32'd1);
    check("rst_avg_4",  32'(avg_hr), 32'd80);
    check("rst_max",    32'(max_hr), 32'd80);
    check("rst_min",    32'(min_hr), 32'd80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
